display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display. It takes the 32-bit nibble-packed `display` word and the 8-bit `displayEnable` mask produced by the sequence automaton and drives one digit at a time. It inserts a programmable blanking gap between digits to suppress ghosting, and latches a tear-free snapshot of its inputs once per frame. It sits between the game logic and the FPGA pins.

---
 rtl/display_scan_ctrl.sv | 117 +++++++++++
 tb/tb_display_scan_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// 8-digit seven-segment scan controller with blanking gap and
// per-frame input snapshot; all outputs registered.
module display_scan_ctrl #(
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] display,
  input  logic [7:0]  displayEnable,
  input  logic [7:0]  dpEnable,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int CW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_TICKS - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_TICKS);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    dig_q, dig_d;
  logic [31:0]   disp_q, disp_d;
  logic [7:0]    en_q, en_d;
  logic [7:0]    dpe_q, dpe_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          fs_q, fs_d;
  logic          wrap, snap, blank;
  logic [3:0]    nib;

  function automatic logic [6:0] dec7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Phase counter and digit index; snapshot point is slot 0, phase 0
  always_comb begin
    wrap  = (cnt_q == CNT_LAST);
    snap  = (cnt_q == '0) && (dig_q == 3'd0);
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    dig_d = wrap ? dig_q + 3'd1 : dig_q;
  end

  // Shadow next-state: the snapshot value is used on its own edge
  always_comb begin
    disp_d = snap ? display       : disp_q;
    en_d   = snap ? displayEnable : en_q;
    dpe_d  = snap ? dpEnable      : dpe_q;
  end

  // Output next-state from current phase/digit and the active shadow
  always_comb begin
    blank = (BLANK_TICKS != 0) && (cnt_q < BLANK_END);
    nib   = disp_d[{dig_q, 2'b00} +: 4];
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    fs_d  = snap;
    if (!blank) begin
      if (en_d[dig_q]) an_d = ~(8'h01 << dig_q);
      seg_d = dec7(nib);
      dp_d  = ~dpe_d[dig_q];
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dig_q  <= 3'd0;
      disp_q <= '0;
      en_q   <= '0;
      dpe_q  <= '0;
      an_q   <= 8'hFF;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      fs_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dig_q  <= dig_d;
      disp_q <= disp_d;
      en_q   <= en_d;
      dpe_q  <= dpe_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      fs_q   <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: per-cycle scoreboard against a
// slot/phase model, frame vector table, and corner sequences.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] display = '0;
  logic [7:0]  displayEnable = '0;
  logic [7:0]  dpEnable = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  display_scan_ctrl #(
    .DIGIT_TICKS(8),
    .BLANK_TICKS(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .display(display),
    .displayEnable(displayEnable),
    .dpEnable(dpEnable),
    .an(an),
    .seg(seg),
    .dp(dp),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } exp_t;

  typedef struct {
    logic [31:0] disp;
    logic [7:0]  en;
    logic [7:0]  dpen;
    logic [6:0]  seg0;
    logic [7:0]  an0;
  } vec_t;

  exp_t sb[$];
  int nvec = 0;
  int nmis = 0;
  int t = 0;
  int ecnt = 0;
  int last_fs = -1;
  logic [31:0] m_disp = '0;
  logic [7:0]  m_en = '0;
  logic [7:0]  m_dp = '0;
  logic [7:0]  prev_an = 8'hFF;
  logic [6:0]  segtab [16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h (edge %0d)", nm, act, exp, ecnt);
    end
  endtask

  task automatic cycle();
    exp_t e;
    exp_t g;
    int slot;
    int ph;
    logic [3:0] nb;
    if (t % 64 == 0) begin
      m_disp = display;
      m_en   = displayEnable;
      m_dp   = dpEnable;
    end
    slot = (t / 8) % 8;
    ph   = t % 8;
    e.fs = (t % 64 == 0);
    if (ph < 2) begin
      e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
    end else begin
      e.an  = m_en[slot] ? ~(8'h01 << slot) : 8'hFF;
      nb    = m_disp[slot*4 +: 4];
      e.seg = segtab[nb];
      e.dp  = ~m_dp[slot];
    end
    sb.push_back(e);
    t++;
    @(posedge clk);
    #1;
    ecnt++;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      g = sb.pop_front();
      chk("an", {24'd0, an}, {24'd0, g.an});
      chk("seg", {25'd0, seg}, {25'd0, g.seg});
      chk("dp", {31'd0, dp}, {31'd0, g.dp});
      chk("frame_start", {31'd0, frame_start}, {31'd0, g.fs});
    end
    chk("an_onecold", $countones(~an), ($countones(~an) > 1) ? 1 : $countones(~an));
    if (prev_an != 8'hFF && an != 8'hFF && an != prev_an)
      chk("an_direct", {24'd0, an}, 32'hFF);
    if (frame_start === 1'b1) begin
      if (last_fs >= 0) chk("fs_period", ecnt - last_fs, 64);
      last_fs = ecnt;
    end
    prev_an = an;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_an", {24'd0, an}, 32'hFF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_fs", {31'd0, frame_start}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    t       = 0;
    ecnt    = 0;
    last_fs = -1;
    prev_an = 8'hFF;
    m_disp  = '0;
    m_en    = '0;
    m_dp    = '0;
    sb.delete();
  endtask

  task automatic align();
    int guard;
    guard = 0;
    while (t % 64 != 0 && guard < 100) begin
      cycle();
      guard++;
    end
  endtask

  vec_t vecs [4];

  initial begin
    segtab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[0] = '{32'h76543210, 8'hFF, 8'h00, 7'h40, 8'hFE};
    vecs[1] = '{32'h0000000A, 8'h01, 8'h00, 7'h08, 8'hFE};
    vecs[2] = '{32'h00000000, 8'h00, 8'h80, 7'h40, 8'hFF};
    vecs[3] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 7'h0E, 8'hFE};

    @(negedge clk);
    display       = 32'h76543210;
    displayEnable = 8'hFF;
    dpEnable      = 8'h00;
    do_reset();
    for (int k = 0; k < 66; k++) begin
      cycle();
      if (k == 0) chk("fs_edge1", {31'd0, frame_start}, 32'd1);
      if (k == 64) chk("fs_edge65", {31'd0, frame_start}, 32'd1);
    end

    for (int v = 0; v < 4; v++) begin
      display       = vecs[v].disp;
      displayEnable = vecs[v].en;
      dpEnable      = vecs[v].dpen;
      align();
      for (int k = 0; k < 64; k++) begin
        cycle();
        if (k == 2) begin
          chk("vec_seg0", {25'd0, seg}, {25'd0, vecs[v].seg0});
          chk("vec_an0", {24'd0, an}, {24'd0, vecs[v].an0});
        end
        if (k == 62 && v == 2) chk("vec_dp7", {31'd0, dp}, 32'd0);
        if (k == 0 && v == 2) chk("vec_dp_blank", {31'd0, dp}, 32'd1);
      end
    end

    display       = 32'h0;
    displayEnable = 8'hFF;
    dpEnable      = 8'h00;
    align();
    for (int k = 0; k < 64; k++) begin
      if (k == 26) display = 32'hFFFFFFFF;
      cycle();
      if (k == 42) chk("midframe_d5", {25'd0, seg}, 32'h40);
    end
    for (int k = 0; k < 64; k++) begin
      cycle();
      if (k == 26) chk("nextframe_d3", {25'd0, seg}, 32'h0E);
    end

    display = 32'h76543210;
    align();
    for (int k = 0; k < 44; k++) cycle();
    chk("pre_rst_d5", {24'd0, an}, 32'hDF);
    do_reset();
    cycle();
    chk("post_rst_fs", {31'd0, frame_start}, 32'd1);
    for (int k = 0; k < 10; k++) cycle();
    chk("post_rst_d1", {24'd0, an}, 32'hFD);

    for (int k = 0; k < 400; k++) begin
      display       = $urandom;
      displayEnable = 8'($urandom);
      dpEnable      = 8'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
